// File: rtl/stat_disp_pkg.sv
// Shared constants for the statistics seven-segment display.
package stat_disp_pkg;

    localparam int NUM_DIGITS = 8;

    // Counter source selects
    localparam logic [2:0] SEL_TOTAL     = 3'd0;
    localparam logic [2:0] SEL_COND      = 3'd1;
    localparam logic [2:0] SEL_UNCOND    = 3'd2;
    localparam logic [2:0] SEL_COND_SUCC = 3'd3;
    localparam logic [2:0] SEL_LU        = 3'd4;

    // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0-F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Binary-to-BCD converter states
    typedef enum logic [0:0] {
        BCD_IDLE = 1'b0,
        BCD_CONV = 1'b1
    } bcd_state_e;

endpackage

// File: rtl/stat_seg_display_seg7_decode.sv
// Nibble to active-low seven-segment pattern {g..a}.
module seg7_decode
    import stat_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    // Look up the glyph and invert for the active-low display
    always_comb begin
        seg_n = ~SEG_HEX[nib];
    end

endmodule

// File: rtl/stat_seg_display.sv
// Performance-counter display: selects one of five counters, snapshots it
// (frozen while the CPU is locked) and scans it onto an 8-digit active-low
// seven-segment display.
// Optional build macro STAT_DISP_BCD_EN: show the snapshot in decimal via a
// 32-cycle sequential double-dabble converter; dp lights on overflow (>8 digits).
module stat_seg_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic [31:0] total,
    input  logic [31:0] conditional,
    input  logic [31:0] unconditional,
    input  logic [31:0] conditional_success,
    input  logic [31:0] lu_times,
    input  logic        lock,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy
);
    import stat_disp_pkg::*;

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [2:0]       sel_q;
    logic [31:0]      snap_q, snap_d, src_mux_s;
    logic [31:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       seg_q, seg_d, an_q, an_d;
    logic             busy_q, busy_d;
    logic             ld_s;
    logic [3:0]       nib_s;
    logic [6:0]       glyph_s;

    // Counter source multiplexer; unused selects read as zero
    always_comb begin
        case (sel)
            SEL_TOTAL:     src_mux_s = total;
            SEL_COND:      src_mux_s = conditional;
            SEL_UNCOND:    src_mux_s = unconditional;
            SEL_COND_SUCC: src_mux_s = conditional_success;
            SEL_LU:        src_mux_s = lu_times;
            default:       src_mux_s = 32'd0;
        endcase
    end

    // Snapshot reloads while running, or on a select change even when halted
    always_comb begin
        ld_s = !lock || (sel != sel_q);
        if (ld_s) begin
            snap_d = src_mux_s;
        end else begin
            snap_d = snap_q;
        end
    end

    // Digit scan divider and registered digit outputs
    always_comb begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
        nib_s = disp_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(8'b0000_0001 << idx_q);
        seg_d = {~ovf_q, glyph_s};
    end

    seg7_decode u_dec (
        .nib   (nib_s),
        .seg_n (glyph_s)
    );

`ifdef STAT_DISP_BCD_EN
    bcd_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [39:0] acc_q, acc_d, adj_s, shifted_s;
    logic [31:0] src_q, src_d, last_q, last_d;

    function automatic logic [39:0] add3_all(input logic [39:0] a);
        logic [39:0] r;
        r = a;
        for (int i = 0; i < 10; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Double-dabble step: add-3 correction then shift in the next source bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        src_d     = src_q;
        last_d    = last_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        adj_s     = add3_all(acc_q);
        shifted_s = {adj_s[38:0], src_q[31]};
        case (state_q)
            BCD_IDLE: begin
                if (snap_q != last_q) begin
                    state_d = BCD_CONV;
                    src_d   = snap_q;
                    last_d  = snap_q;
                    acc_d   = 40'd0;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = BCD_IDLE;
                end
            end
            BCD_CONV: begin
                acc_d = shifted_s;
                src_d = {src_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = BCD_IDLE;
                    disp_d  = shifted_s[31:0];
                    ovf_d   = |shifted_s[39:32];
                end else begin
                    state_d = BCD_CONV;
                end
            end
            default: state_d = BCD_IDLE;
        endcase
        busy_d = (state_d == BCD_CONV);
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BCD_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 40'd0;
            src_q   <= 32'd0;
            last_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end
`else
    // Hex build: display follows the snapshot one cycle later
    always_comb begin
        disp_d = snap_q;
        ovf_d  = 1'b0;
        busy_d = 1'b0;
    end
`endif

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= 3'd0;
            snap_q <= 32'd0;
            disp_q <= 32'd0;
            ovf_q  <= 1'b0;
            div_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 8'hFF;
            an_q   <= 8'hFF;
            busy_q <= 1'b0;
        end else begin
            sel_q  <= sel;
            snap_q <= snap_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            busy_q <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule
